// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - op codes, FSM state encoding and default width for the ALU sequencer
package alu_pkg;

  localparam int WIDTH_DEFAULT = 4;
  localparam int OP_W          = 3;

  localparam logic [OP_W-1:0] OP_INC   = 3'd0;
  localparam logic [OP_W-1:0] OP_ADD   = 3'd1;
  localparam logic [OP_W-1:0] OP_ACC   = 3'd2;
  localparam logic [OP_W-1:0] OP_LOGIC = 3'd3;
  localparam logic [OP_W-1:0] OP_RED   = 3'd4;
  localparam logic [OP_W-1:0] OP_CAT   = 3'd5;
  localparam logic [OP_W-1:0] OP_MUL   = 3'd6;
  localparam logic [OP_W-1:0] OP_CLR   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// rtl/alu_op_sequencer_if.sv - command/result handshake bundle of the ALU sequencer
interface alu_op_sequencer_if
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
);

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [OP_W-1:0]       cmd_op;
  logic [WIDTH-1:0]      cmd_a;
  logic [WIDTH-1:0]      cmd_b;
  logic                  cmd_use_acc;
  logic                  res_valid;
  logic                  res_ready;
  logic [2*WIDTH-1:0]    res_data;
  logic [2*WIDTH-1:0]    acc_q;
  logic                  busy;

  // Command source / result consumer side
  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc, res_ready,
    input  cmd_ready, res_valid, res_data, acc_q, busy
  );

  // Sequencer side
  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc, res_ready,
    output cmd_ready, res_valid, res_data, acc_q, busy
  );

endinterface

// File: rtl/alu_fn_unit.sv
// rtl/alu_fn_unit.sv - combinational function unit for all single-cycle ALU ops
module alu_fn_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [OP_W-1:0]    op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2*WIDTH-1:0] acc,
  output logic [2*WIDTH-1:0] result
);

  logic [WIDTH-1:0] add_y;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;
  logic             carry;

  // Ripple-carry adder shared by increment (y = 1) and add (y = B); carry-out is kept
  always_comb begin
    add_y   = (op == OP_INC) ? WIDTH'(1) : b;
    add_sum = '0;
    carry   = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      add_sum[i] = a[i] ^ add_y[i] ^ carry;
      carry      = (a[i] & add_y[i]) | (carry & (a[i] ^ add_y[i]));
    end
    add_cout = carry;
  end

  // Op select; results are zero-extended to the accumulator width
  always_comb begin
    result = '0;
    case (op)
      OP_INC,
      OP_ADD:   result = {{(WIDTH-1){1'b0}}, add_cout, add_sum};
      OP_ACC:   result = acc + {{WIDTH{1'b0}}, a};
      OP_LOGIC: result = {a | b, a ^ b};
      OP_RED:   result = {{(2*WIDTH-1){1'b0}}, |{a, b}};
      OP_CAT:   result = {a, b};
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - multi-cycle ALU controller with shift-add multiply and accumulator
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEFAULT,
  parameter int MUL_STEPS = WIDTH
) (
  input logic              clk,
  input logic              reset,
  alu_op_sequencer_if.slave bus
);

  localparam int CNT_W = $clog2(MUL_STEPS + 1);

  state_t               state;
  logic [OP_W-1:0]      op_q;
  logic [WIDTH-1:0]     a_q;
  logic [WIDTH-1:0]     b_q;
  logic [2*WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0]   prod_q;
  logic [CNT_W-1:0]     step_q;
  logic [2*WIDTH-1:0]   res_data_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic                 cmd_ready_q;
  logic                 res_valid_q;
  logic                 busy_q;

  logic [WIDTH-1:0]     b_sel;
  logic [2*WIDTH-1:0]   fn_result;
  logic [2*WIDTH-1:0]   prod_next;

  // Operand B comes from the accumulator low half when chaining
  assign b_sel = bus.cmd_use_acc ? acc_q[WIDTH-1:0] : bus.cmd_b;

  // One shift-add step: add the shifted multiplicand when the current multiplier LSB is set
  assign prod_next = prod_q + (b_q[0] ? mcand_q : '0);

  alu_fn_unit #(
    .WIDTH (WIDTH)
  ) u_fn_unit (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .acc    (acc_q),
    .result (fn_result)
  );

  // Sequencer FSM with registered handshake outputs, operand, multiply and accumulator state
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      mcand_q     <= '0;
      prod_q      <= '0;
      step_q      <= '0;
      res_data_q  <= '0;
      acc_q       <= '0;
      cmd_ready_q <= 1'b1;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.cmd_valid && cmd_ready_q) begin
            op_q        <= bus.cmd_op;
            a_q         <= bus.cmd_a;
            b_q         <= b_sel;
            mcand_q     <= {{WIDTH{1'b0}}, bus.cmd_a};
            prod_q      <= '0;
            step_q      <= '0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state       <= (bus.cmd_op == OP_MUL) ? ST_MUL : ST_EXEC;
          end
        end
        ST_EXEC: begin
          res_data_q  <= fn_result;
          res_valid_q <= 1'b1;
          state       <= ST_DONE;
        end
        ST_MUL: begin
          prod_q  <= prod_next;
          mcand_q <= mcand_q << 1;
          b_q     <= b_q >> 1;
          step_q  <= step_q + 1'b1;
          if (step_q == CNT_W'(MUL_STEPS - 1)) begin
            res_data_q  <= prod_next;
            res_valid_q <= 1'b1;
            state       <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.res_ready) begin
            acc_q       <= res_data_q;
            res_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.acc_q     = acc_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - directed scoreboard bench for alu_op_sequencer
module tb_alu_op_sequencer;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;
  logic [7:0] exp_q[$];
  logic [7:0] acc_m;

  alu_op_sequencer_if #(.WIDTH(4)) bus ();

  alu_op_sequencer #(
    .WIDTH     (4),
    .MUL_STEPS (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model(input logic [2:0] op, input logic [3:0] a,
                                       input logic [3:0] b, input logic [7:0] acc);
    case (op)
      3'd0:    return {4'h0, a} + 8'd1;
      3'd1:    return {4'h0, a} + {4'h0, b};
      3'd2:    return acc + {4'h0, a};
      3'd3:    return {a | b, a ^ b};
      3'd4:    return {7'd0, (a != 4'h0) || (b != 4'h0)};
      3'd5:    return {a, b};
      3'd6:    return {4'h0, a} * {4'h0, b};
      default: return 8'h00;
    endcase
  endfunction

  // Issue one command and return once it has been accepted; leaves the bench in the accept cycle's next negedge
  task automatic issue(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b, input logic use_acc);
    logic [3:0] b_eff;
    b_eff = use_acc ? acc_m[3:0] : b;
    exp_q.push_back(model(op, a, b_eff, acc_m));
    @(negedge clk);
    bus.cmd_valid   = 1'b1;
    bus.cmd_op      = op;
    bus.cmd_a       = a;
    bus.cmd_b       = b;
    bus.cmd_use_acc = use_acc;
    check("cmd_ready_idle", {15'd0, bus.cmd_ready}, 16'd1);
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid   = 1'b0;
    bus.cmd_op      = 3'($urandom_range(0, 7));
    bus.cmd_a       = 4'($urandom_range(0, 15));
    bus.cmd_b       = 4'($urandom_range(0, 15));
    bus.cmd_use_acc = 1'b0;
  endtask

  // Full transaction: latency, busy, result, hold behaviour and accumulator after handshake
  task automatic run_op(input string tag, input logic [2:0] op, input logic [3:0] a,
                        input logic [3:0] b, input logic use_acc, input int lat_exp, input int hold);
    int lat;
    logic [7:0] exp;
    issue(op, a, b, use_acc);
    lat = 1;
    while (bus.res_valid !== 1'b1 && lat <= 20) begin
      check({tag, "_busy"}, {15'd0, bus.busy}, 16'd1);
      check({tag, "_cmd_ready_busy"}, {15'd0, bus.cmd_ready}, 16'd0);
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    exp = exp_q.pop_front();
    if (lat > 20) begin
      check({tag, "_timeout"}, 16'd0, 16'd1);
      return;
    end
    check({tag, "_latency"}, 16'(lat), 16'(lat_exp));
    check({tag, "_res_data"}, {8'd0, bus.res_data}, {8'd0, exp});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      check({tag, "_hold_valid"}, {15'd0, bus.res_valid}, 16'd1);
      check({tag, "_hold_data"}, {8'd0, bus.res_data}, {8'd0, exp});
      check({tag, "_hold_cmd_ready"}, {15'd0, bus.cmd_ready}, 16'd0);
    end
    bus.res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.res_ready = 1'b0;
    acc_m = exp;
    check({tag, "_valid_drop"}, {15'd0, bus.res_valid}, 16'd0);
    check({tag, "_ready_back"}, {15'd0, bus.cmd_ready}, 16'd1);
    check({tag, "_busy_idle"}, {15'd0, bus.busy}, 16'd0);
    check({tag, "_acc"}, {8'd0, bus.acc_q}, {8'd0, acc_m});
  endtask

  initial begin
    n_tests         = 0;
    n_fail          = 0;
    acc_m           = 8'h00;
    reset           = 1'b1;
    bus.cmd_valid   = 1'b0;
    bus.cmd_op      = 3'd0;
    bus.cmd_a       = 4'h0;
    bus.cmd_b       = 4'h0;
    bus.cmd_use_acc = 1'b0;
    bus.res_ready   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_cmd_ready", {15'd0, bus.cmd_ready}, 16'd1);
    check("rst_res_valid", {15'd0, bus.res_valid}, 16'd0);
    check("rst_res_data", {8'd0, bus.res_data}, 16'd0);
    check("rst_acc", {8'd0, bus.acc_q}, 16'd0);
    check("rst_busy", {15'd0, bus.busy}, 16'd0);

    run_op("inc_f", 3'd0, 4'hF, 4'h0, 1'b0, 2, 0);
    run_op("add_useacc", 3'd1, 4'h5, 4'hA, 1'b1, 2, 0);
    run_op("cat_f8", 3'd5, 4'hF, 4'h8, 1'b0, 2, 0);
    run_op("acc_wrap", 3'd2, 4'hF, 4'h0, 1'b0, 2, 0);
    run_op("logic", 3'd3, 4'b1100, 4'b1010, 1'b0, 2, 0);
    run_op("cat_3c", 3'd5, 4'h3, 4'hC, 1'b0, 2, 0);
    run_op("add_carry", 3'd1, 4'hF, 4'h1, 1'b0, 2, 0);
    run_op("mul_ff", 3'd6, 4'hF, 4'hF, 1'b0, 5, 0);
    run_op("mul_useacc", 3'd6, 4'h3, 4'h0, 1'b1, 5, 0);
    run_op("red_zero", 3'd4, 4'h0, 4'h0, 1'b0, 2, 0);
    run_op("red_one", 3'd4, 4'h0, 4'h2, 1'b0, 2, 0);
    run_op("hold10", 3'd5, 4'hA, 4'h5, 1'b0, 2, 10);

    // Reset during the second MUL cycle discards the product and the accumulator
    issue(3'd6, 4'h7, 4'h9, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("mid_mul_busy", {15'd0, bus.busy}, 16'd1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    void'(exp_q.pop_front());
    acc_m = 8'h00;
    check("mulrst_res_valid", {15'd0, bus.res_valid}, 16'd0);
    check("mulrst_acc", {8'd0, bus.acc_q}, 16'd0);
    check("mulrst_cmd_ready", {15'd0, bus.cmd_ready}, 16'd1);
    check("mulrst_busy", {15'd0, bus.busy}, 16'd0);
    repeat (6) begin
      @(posedge clk);
      @(negedge clk);
      check("mulrst_no_valid", {15'd0, bus.res_valid}, 16'd0);
    end

    run_op("inc_1", 3'd0, 4'h1, 4'h0, 1'b0, 2, 0);
    run_op("clr", 3'd7, 4'h9, 4'h9, 1'b0, 2, 2);
    run_op("acc_after_clr", 3'd2, 4'h4, 4'h0, 1'b0, 2, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
